// File: rtl/mad_tx_sched_if.sv
// Result handshake between the minimum-MAD search stage and the transmit scheduler.
interface mad_tx_sched_if;
    logic        valid;
    logic        ready;
    logic [7:0]  coord;
    logic [11:0] mad;

    modport master (output valid, coord, mad, input ready);
    modport slave  (input valid, coord, mad, output ready);
endinterface

// File: rtl/mad_tx_sched.sv
// Queues block-matching results and launches them as 20-bit serial frames:
// a load strobe per frame, a fixed shift window, an optional idle gap, and a frame-sync pulse.
module mad_tx_sched #(
    parameter int unsigned FIFO_DEPTH = 2,
    parameter int unsigned GAP_CYCLES = 0,
    parameter int unsigned FRAME_BITS = 20
) (
    input  logic                          clk,
    input  logic                          rst_n,
    mad_tx_sched_if.slave                 res,
    input  logic                          tx_en_i,
    output logic                          ser_load_o,
    output logic [7:0]                    ser_coord_o,
    output logic [11:0]                   ser_mad_o,
    output logic                          frame_sync_o,
    output logic                          busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic [15:0]                   frame_cnt_o
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL     = CW'(FIFO_DEPTH);
    localparam logic [4:0]    LAST_BIT = 5'(FRAME_BITS - 2);
    localparam logic [3:0]    LAST_GAP = 4'(GAP_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, GAP} state_e;

    state_e        state_q, state_d;
    logic [4:0]    bit_cnt_q;
    logic [3:0]    gap_cnt_q;
    logic          ser_load_q, frame_sync_q;
    logic [7:0]    ser_coord_q;
    logic [11:0]   ser_mad_q;
    logic [15:0]   frame_cnt_q;

    logic [19:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, start, last_bit, last_gap, launch;

    // Ready comes from the registered count only, so a full queue never accepts even while popping.
    assign res.ready = (count_q != FULL);
    assign push      = res.valid && res.ready;
    assign pop       = (state_q == LOAD);

    always_comb begin
        // NOTE: every always_comb output gets a default first, so no path can leave it unassigned and infer a latch.
        count_d = count_q;
        if (push && !pop)      count_d = count_q + 1'b1;
        else if (pop && !push) count_d = count_q - 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
        end
    end

    // NOTE: payload storage has no reset; validity is defined by the pointers and count alone.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {res.coord, res.mad};
    end

    assign start    = tx_en_i && (count_q != '0);
    assign last_bit = (state_q == SHIFT) && (bit_cnt_q == LAST_BIT);
    assign last_gap = (state_q == GAP) && (gap_cnt_q == LAST_GAP);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = LOAD;
            LOAD:    state_d = SHIFT;
            SHIFT:   if (last_bit) begin
                         if (GAP_CYCLES != 0) state_d = GAP;
                         else                 state_d = start ? LOAD : IDLE;
                     end
            GAP:     if (last_gap) state_d = start ? LOAD : IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign launch = (state_d == LOAD);

    // Outputs are registered on entry to LOAD so the strobe and head word appear during the LOAD cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            ser_load_q   <= 1'b0;
            ser_coord_q  <= '0;
            ser_mad_q    <= '0;
            frame_sync_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            state_q      <= state_d;
            ser_load_q   <= launch;
            frame_sync_q <= (state_q == SHIFT) && (bit_cnt_q == '0);
            if (launch) {ser_coord_q, ser_mad_q} <= mem_q[rd_ptr_q];
            if (state_q == LOAD) frame_cnt_q <= frame_cnt_q + 16'd1;
            bit_cnt_q    <= (state_q == SHIFT) ? bit_cnt_q + 5'd1 : '0;
            gap_cnt_q    <= (state_q == GAP) ? gap_cnt_q + 4'd1 : '0;
        end
    end

    assign ser_load_o   = ser_load_q;
    assign ser_coord_o  = ser_coord_q;
    assign ser_mad_o    = ser_mad_q;
    assign frame_sync_o = frame_sync_q;
    assign frame_cnt_o  = frame_cnt_q;
    assign fifo_count_o = count_q;
    assign busy_o       = (state_q != IDLE) || (count_q != '0);
endmodule

// File: tb/tb_mad_tx_sched.sv
// Self-checking bench: two schedulers (gap 0 and gap 3) share stimulus and are compared
// every cycle against a transaction-level model of queue contents and frame launch times.
module tb_mad_tx_sched;
    localparam int DEPTH = 2;
    localparam int PERIOD_BASE = 20;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, valid, tx_en;
    logic [7:0]  coord;
    logic [11:0] mad;

    mad_tx_sched_if rif0 ();
    mad_tx_sched_if rif1 ();
    assign rif0.valid = valid;
    assign rif0.coord = coord;
    assign rif0.mad   = mad;
    assign rif1.valid = valid;
    assign rif1.coord = coord;
    assign rif1.mad   = mad;

    logic        ser_load [2];
    logic        frame_sync [2];
    logic        busy [2];
    logic        ready [2];
    logic [7:0]  ser_coord [2];
    logic [11:0] ser_mad [2];
    logic [1:0]  fifo_count [2];
    logic [15:0] frame_cnt [2];
    assign ready[0] = rif0.ready;
    assign ready[1] = rif1.ready;

    mad_tx_sched #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(0), .FRAME_BITS(20)) dut0 (
        .clk(clk), .rst_n(rst_n), .res(rif0), .tx_en_i(tx_en),
        .ser_load_o(ser_load[0]), .ser_coord_o(ser_coord[0]), .ser_mad_o(ser_mad[0]),
        .frame_sync_o(frame_sync[0]), .busy_o(busy[0]), .fifo_count_o(fifo_count[0]),
        .frame_cnt_o(frame_cnt[0]));

    mad_tx_sched #(.FIFO_DEPTH(DEPTH), .GAP_CYCLES(3), .FRAME_BITS(20)) dut1 (
        .clk(clk), .rst_n(rst_n), .res(rif1), .tx_en_i(tx_en),
        .ser_load_o(ser_load[1]), .ser_coord_o(ser_coord[1]), .ser_mad_o(ser_mad[1]),
        .frame_sync_o(frame_sync[1]), .busy_o(busy[1]), .fifo_count_o(fifo_count[1]),
        .frame_cnt_o(frame_cnt[1]));

    // Downstream serializer for dut0: loads at the strobe edge, MSB reaches the line two cycles after LOAD.
    logic [19:0] sreg;
    logic        sout;
    always @(posedge clk) begin
        sout <= sreg[19];
        sreg <= ser_load[0] ? {ser_coord[0], ser_mad[0]} : {sreg[18:0], 1'b0};
    end

    logic [19:0] q0[$];
    logic [19:0] q1[$];
    int          load_at [2];
    int          dec_from [2];
    int          last_l [2];
    bit          has_l [2];
    logic [15:0] fcnt [2];
    logic [19:0] hw [2];
    logic [19:0] lw [2];

    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;
    bit          model_ok = 1'b0;
    bit          rx_on = 1'b0;
    int          rx_bits = 0;
    logic [19:0] rx_word, rx_exp;
    logic [19:0] last_rx = '0;

    function automatic int gap_of(input int d);
        return (d == 0) ? 0 : 3;
    endfunction

    function automatic int qsize(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic logic [19:0] qfront(input int d);
        return (d == 0) ? q0[0] : q1[0];
    endfunction

    task automatic qpop(input int d);
        if (d == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endtask

    task automatic qpush(input int d, input logic [19:0] w);
        if (d == 0) q0.push_back(w);
        else        q1.push_back(w);
    endtask

    task automatic check(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s dut%0d cyc=%0d observed=%0h expected=%0h", tag, d, cyc, obs, exp);
        end
    endtask

    task automatic model_reset(input int d);
        if (d == 0) q0.delete();
        else        q1.delete();
        load_at[d]  = -1;
        dec_from[d] = 0;
        has_l[d]    = 1'b0;
        last_l[d]   = 0;
        fcnt[d]     = '0;
        hw[d]       = '0;
    endtask

    // One cycle of the reference: compare outputs, then apply pop / launch decision / push.
    task automatic model_cycle(input int d);
        int  sz;
        int  g;
        bit  nonidle;
        sz = qsize(d);
        g  = gap_of(d);
        if (model_ok) begin
            if (cyc == load_at[d]) hw[d] = qfront(d);
            nonidle = (cyc == load_at[d]) || (has_l[d] && cyc <= last_l[d] + PERIOD_BASE - 1 + g);
            check("ser_load",   d, ser_load[d],   (cyc == load_at[d]));
            check("ser_coord",  d, ser_coord[d],  hw[d][19:12]);
            check("ser_mad",    d, ser_mad[d],    hw[d][11:0]);
            check("fifo_count", d, fifo_count[d], sz);
            check("res_ready",  d, ready[d],      (sz < DEPTH));
            check("busy",       d, busy[d],       (nonidle || sz != 0));
            check("frame_sync", d, frame_sync[d], (has_l[d] && cyc == last_l[d] + 2));
            check("frame_cnt",  d, frame_cnt[d],  fcnt[d]);
        end
        if (!rst_n) begin
            model_reset(d);
            return;
        end
        if (cyc == load_at[d]) begin
            lw[d] = qfront(d);
            qpop(d);
            fcnt[d]     = fcnt[d] + 16'd1;
            last_l[d]   = cyc;
            has_l[d]    = 1'b1;
            dec_from[d] = cyc + PERIOD_BASE - 1 + g;
            load_at[d]  = -1;
        end else if (load_at[d] < 0 && cyc >= dec_from[d] && tx_en && sz != 0) begin
            load_at[d] = cyc + 1;
        end
        if (valid && sz < DEPTH) qpush(d, {coord, mad});
    endtask

    task automatic tick(input logic r, input logic v, input logic [7:0] c, input logic [11:0] m, input logic t);
        rst_n = r;
        valid = v;
        coord = c;
        mad   = m;
        tx_en = t;
        if (model_ok && has_l[0] && cyc == last_l[0] + 2) begin
            rx_on   = 1'b1;
            rx_bits = 0;
            rx_exp  = lw[0];
        end
        if (rx_on) begin
            rx_word = {rx_word[18:0], sout};
            rx_bits++;
            if (rx_bits == 20) begin
                check("serial_word", 0, rx_word, rx_exp);
                last_rx = rx_word;
                rx_on   = 1'b0;
            end
        end
        if (!r) rx_on = 1'b0;
        model_cycle(0);
        model_cycle(1);
        if (!r) model_ok = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic idle(input int n, input logic t);
        for (int k = 0; k < n; k++) tick(1'b1, 1'b0, 8'h00, 12'h000, t);
    endtask

    // Holds valid until dut0 accepts the word; an expired budget counts as a failure.
    task automatic send(input logic [7:0] c, input logic [11:0] m, input logic t);
        bit acc;
        acc = 1'b0;
        for (int k = 0; k < 50 && !acc; k++) begin
            acc = ready[0];
            tick(1'b1, 1'b1, c, m, t);
        end
        check("send_accepted", 0, acc, 1'b1);
    endtask

    initial begin
        rst_n = 1'b0;
        valid = 1'b0;
        tx_en = 1'b0;
        coord = '0;
        mad   = '0;

        // Reset held three cycles while valid is asserted: nothing may be queued.
        for (int k = 0; k < 3; k++) tick(1'b0, 1'b1, 8'h11, 12'h222, 1'b1);
        check("rst_ready",     0, ready[0],      1'b1);
        check("rst_fifo",      0, fifo_count[0], 2'd0);
        check("rst_frame_cnt", 0, frame_cnt[0],  16'd0);

        // Single result, earliest latency.
        tick(1'b1, 1'b1, 8'hA5, 12'h3C7, 1'b1);
        idle(1, 1'b1);
        check("single_load", 0, ser_load[0], 1'b1);
        check("single_word", 0, {ser_coord[0], ser_mad[0]}, 20'hA53C7);
        idle(30, 1'b1);
        check("single_cnt",    0, frame_cnt[0], 16'd1);
        check("single_serial", 0, last_rx,      20'hA53C7);
        check("single_busy",   0, busy[0],      1'b0);

        // Back-to-back frames.
        send(8'h12, 12'h345, 1'b1);
        send(8'h67, 12'h89A, 1'b1);
        send(8'hBC, 12'hDEF, 1'b1);
        idle(70, 1'b1);
        check("b2b_cnt",    0, frame_cnt[0], 16'd4);
        check("b2b_serial", 0, last_rx,      20'hBCDEF);

        // tx_en gating: hold two results, release for one cycle, frame completes without a second load.
        send(8'h5A, 12'h0F0, 1'b0);
        send(8'hC3, 12'hF0F, 1'b0);
        idle(5, 1'b0);
        check("gate_busy", 0, busy[0],       1'b1);
        check("gate_fifo", 0, fifo_count[0], 2'd2);
        check("gate_load", 0, ser_load[0],   1'b0);
        idle(1, 1'b1);
        check("gate_launch", 0, ser_load[0], 1'b1);
        idle(30, 1'b0);
        check("gate_fifo_after", 0, fifo_count[0], 2'd1);
        check("gate_cnt",        0, frame_cnt[0],  16'd5);
        idle(60, 1'b1);

        // Reset in the middle of SHIFT with one entry still queued.
        send(8'h3E, 12'h7A1, 1'b0);
        send(8'h4F, 12'h8B2, 1'b0);
        idle(1, 1'b1);
        idle(8, 1'b1);
        tick(1'b0, 1'b0, 8'h00, 12'h000, 1'b1);
        check("abort_fifo", 0, fifo_count[0], 2'd0);
        check("abort_cnt",  0, frame_cnt[0],  16'd0);
        check("abort_busy", 0, busy[0],       1'b0);
        tick(1'b1, 1'b1, 8'h96, 12'h5C3, 1'b1);
        idle(1, 1'b1);
        check("restart_load", 0, ser_load[0], 1'b1);
        idle(30, 1'b1);
        check("restart_serial", 0, last_rx, 20'h965C3);

        // Randomized traffic with occasional resets and tx_en drops.
        for (int k = 0; k < 700; k++) begin
            tick(($urandom_range(0, 199) != 0), ($urandom_range(0, 2) != 0),
                 8'($urandom), 12'($urandom), ($urandom_range(0, 7) != 0));
        end
        idle(60, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
